fifo_sync_prog: RTL
===================

Name: fifo_sync_prog

Overview:
- Parametrised synchronous FIFO; next generation of the team's DATA_W/DEPTH/UPP_TH/LOW_TH FIFO.
- Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in one clock domain; the existing driver/monitor bench structure applies unchanged.

Parameters:
- DATA_W, 128, data word width in bits (>=1).
- DEPTH, 1024, number of entries; power of two, >=4.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- CNT_W, $clog2(DEPTH)+1, derived; width of count, pointers and thresholds. Not to be overridden.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- i_flush, input, 1, synchronous flush; empties the FIFO.
- i_wren, input, 1, write request.
- i_wrdata, input, DATA_W, write data.
- i_rden, input, 1, read request (pop).
- i_upp_th, input, CNT_W, almost-full threshold.
- i_low_th, input, CNT_W, almost-empty threshold.
- o_rddata, output, DATA_W, read data.
- o_rdvalid, output, 1, o_rddata qualifier.
- o_full, output, 1, count == DEPTH.
- o_empty, output, 1, count == 0.
- o_alm_full, output, 1, count >= i_upp_th.
- o_alm_empty, output, 1, count <= i_low_th.
- o_count, output, CNT_W, current occupancy, 0..DEPTH.
- o_overflow, output, 1, one-cycle pulse: rejected write.
- o_underflow, output, 1, one-cycle pulse: rejected read.

Behaviour:
- Reset (rstn low, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - o_empty = 1, o_alm_empty = 1; o_full = 0, o_alm_full = 0.
  - o_rddata = 0, o_rdvalid = 0, o_overflow = 0, o_underflow = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data immediately.
- Acceptance rules:
  - Write accepted iff i_wren && !o_full && !i_flush.
  - Read accepted iff i_rden && !o_empty && !i_flush.
  - Both are evaluated on the registered flags at the edge.
- Simultaneous read and write:
  - When neither flag blocks, both are accepted and count is unchanged.
  - When full, the read is accepted, the write is rejected, and o_overflow pulses.
  - When empty, the write is accepted, the read is rejected, and o_underflow pulses. There is no write-through.
- Pointers:
  - CNT_W bits wide; memory address = low $clog2(DEPTH) bits.
  - Wrap at DEPTH is natural binary rollover.
  - count = wr_ptr - rd_ptr, held as a register.
- Flags:
  - Derived combinationally from the registered count and the live thresholds.
  - Valid the cycle after the accepted operation.
  - Threshold changes take effect on the same cycle; no sampling.
- Threshold edge values:
  - i_upp_th = 0 forces o_alm_full = 1.
  - i_upp_th > DEPTH forces o_alm_full = 0.
  - i_low_th >= DEPTH forces o_alm_empty = 1.
- Standard mode (FWFT = 0):
  - Accepted read at edge N: o_rddata is registered from mem[rd_ptr] and o_rdvalid = 1 after edge N, so data is valid one cycle after the request cycle.
  - o_rdvalid is 0 on cycles with no accepted read.
  - o_rddata holds its last value when no read is accepted.
- FWFT mode (FWFT = 1):
  - o_rddata = mem[rd_ptr] combinationally; o_rdvalid = !o_empty.
  - An accepted i_rden advances to the next word, which is visible the following cycle.
  - A write to an empty FIFO at edge N is visible on o_rddata with o_rdvalid = 1 after edge N.
- Flush (i_flush = 1 at an edge):
  - Takes priority over everything except reset.
  - Pointers and count = 0; concurrent i_wren/i_rden are ignored.
  - No overflow or underflow pulse is generated.
  - Standard mode: o_rdvalid = 0 next cycle and o_rddata holds.
- Error pulses:
  - o_overflow and o_underflow are registered, high for exactly one cycle after the offending edge.
  - State is never altered by a rejected request.

Test Plan:
- Reset and fill (DEPTH=8, FWFT=0, i_upp_th=6, i_low_th=2): 8 writes 0x1..0x8 → o_count steps 1..8; o_alm_empty drops when count = 3; o_alm_full rises when count = 6; o_full = 1 at 8; 9th write → o_overflow pulse and count stays 8.
- Drain in order: 8 reads → o_rddata 0x1..0x8, each one cycle after its request with o_rdvalid pulses; o_empty = 1 after the last; a further read → o_underflow pulse.
- Wrap-around: 5 writes, 5 reads, then 6 writes 0xA..0xF → reads return 0xA..0xF in order; o_count correct across the pointer rollover.
- Simultaneous operations: at count 4, wren+rden for 10 cycles → count stays 4 and data stays ordered; when full, wren+rden → read data returned, o_overflow = 1, count = 7; when empty, wren+rden → o_underflow = 1, count = 1.
- FWFT=1: write 0x55 to empty FIFO → o_rddata = 0x55 and o_rdvalid = 1 the next cycle without i_rden; pop → o_rdvalid = 0.
- Flush and async reset: at count 5, i_flush with wren → count = 0, o_empty = 1, no error pulses; rstn low mid-burst → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with runtime-programmable almost-full/almost-empty thresholds,
// occupancy count, synchronous flush, error pulses and optional first-word-fall-through.
module fifo_sync_prog #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024,
  parameter int FWFT   = 0,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_flush,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic [CNT_W-1:0]  i_upp_th,
  input  logic [CNT_W-1:0]  i_low_th,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_wr_acc  = i_wren && !w_full && !i_flush;
  assign w_rd_acc  = i_rden && !w_empty && !i_flush;
  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  // Plain unsigned compares already give the threshold edge cases:
  // upp_th=0 is always met, upp_th>DEPTH never, low_th>=DEPTH always.
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_alm_full  = (r_count >= i_upp_th);
  assign o_alm_empty = (r_count <= i_low_th);
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= i_wrdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
      r_overflow  <= i_wren && w_full;
      r_underflow <= i_rden && w_empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; zeroed while empty so reset reads as 0.
      assign o_rddata  = w_empty ? '0 : r_mem[w_rd_addr];
      assign o_rdvalid = !w_empty;
    end else begin : g_std
      logic [DATA_W-1:0] r_rddata;
      logic              r_rdvalid;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_rddata  <= '0;
          r_rdvalid <= 1'b0;
        end else begin
          r_rdvalid <= w_rd_acc;
          if (w_rd_acc) r_rddata <= r_mem[w_rd_addr];
        end
      end

      assign o_rddata  = r_rddata;
      assign o_rdvalid = r_rdvalid;
    end
  endgenerate

endmodule
